// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared encodings for the pipeline controller.
//   op_e    : decoded instruction op (BR/ADD/LDW/STW)
//   state_e : branch-flush FSM states
//   stage_t : {valid, op, dr} tracked per downstream stage
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_BR  = 2'b00,
        OP_ADD = 2'b01,
        OP_LDW = 2'b10,
        OP_STW = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_FLUSH1 = 2'b01,
        ST_FLUSH2 = 2'b10
    } state_e;

    typedef struct packed {
        logic       valid;
        op_e        op;
        logic [2:0] dr;
    } stage_t;

    // Bubbles carry op=BR / dr=0 so they never look like a register writer.
    localparam stage_t BUBBLE = '{valid: 1'b0, op: OP_BR, dr: 3'b000};

    // ADD and LDW are the ops that update the condition codes.
    function automatic logic sets_cc(input stage_t s);
        return s.valid && (s.op == OP_ADD || s.op == OP_LDW);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// sat_counter16
//   16-bit up counter with synchronous reset that sticks at 16'hFFFF.
//   clk_i : clock
//   rst_i : synchronous active-high clear
//   en_i  : count this cycle
//   cnt_o : current count
module sat_counter16 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Hazard / branch controller for a 5-stage pipeline. Tracks {valid,op,dr}
//   for EX/MEM/WB, detects load-use and condition-code hazards against the
//   instruction in ID, redirects on taken branches and squashes the two
//   wrong-path fetches that follow.
//   CLK, RESET (sync, active high)
//   ID_VALID, ID_OP, ID_SR1, ID_SR2, ID_DR, ID_USES_SR2, BR_TAKEN : ID inputs
//   STALL, REDIRECT, ID_SQUASH                   : pipeline control
//   OP_EX/MEM/WB, DR_EX/MEM/WB, WB_ENABLE        : stage tracker view
//   STALL_CNT, BR_CNT                            : saturating perf counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ID_VALID,
    input  logic [1:0]  ID_OP,
    input  logic [2:0]  ID_SR1,
    input  logic [2:0]  ID_SR2,
    input  logic [2:0]  ID_DR,
    input  logic        ID_USES_SR2,
    input  logic        BR_TAKEN,
    output logic        STALL,
    output logic        REDIRECT,
    output logic        ID_SQUASH,
    output logic [1:0]  OP_EX,
    output logic [1:0]  OP_MEM,
    output logic [1:0]  OP_WB,
    output logic [2:0]  DR_EX,
    output logic [2:0]  DR_MEM,
    output logic [2:0]  DR_WB,
    output logic        WB_ENABLE,
    output logic [15:0] STALL_CNT,
    output logic [15:0] BR_CNT
);

    state_e state_q, state_d;
    stage_t ex_q, mem_q, wb_q;
    stage_t ex_d;

    logic idv;
    logic id_is_br;
    logic load_use;
    logic cc_haz;

    assign ID_SQUASH = (state_q != ST_RUN);
    assign idv       = ID_VALID && !ID_SQUASH;
    assign id_is_br  = (ID_OP == OP_BR);

    // Loaded value is available by MEM forwarding one cycle later, so a
    // single bubble is enough. Branches don't read GPRs, hence the op check.
    assign load_use = idv && ex_q.valid && ex_q.op == OP_LDW && !id_is_br &&
                      (ID_SR1 == ex_q.dr || (ID_USES_SR2 && ID_SR2 == ex_q.dr));

    // A branch must wait until no older CC writer sits in EX or MEM.
    assign cc_haz = idv && id_is_br && (sets_cc(ex_q) || sets_cc(mem_q));

    assign STALL = load_use || cc_haz;

    // load_use excludes branches, so REDIRECT and STALL are mutually exclusive.
    assign REDIRECT = (state_q == ST_RUN) && idv && id_is_br && BR_TAKEN && !cc_haz;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (REDIRECT) state_d = ST_FLUSH1;
            ST_FLUSH1: state_d = ST_FLUSH2;
            ST_FLUSH2: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        ex_d = BUBBLE;
        if (idv && !STALL)
            ex_d = '{valid: 1'b1, op: op_e'(ID_OP), dr: ID_DR};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RUN;
            ex_q    <= BUBBLE;
            mem_q   <= BUBBLE;
            wb_q    <= BUBBLE;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
        end
    end

    assign OP_EX     = ex_q.op;
    assign OP_MEM    = mem_q.op;
    assign OP_WB     = wb_q.op;
    assign DR_EX     = ex_q.dr;
    assign DR_MEM    = mem_q.dr;
    assign DR_WB     = wb_q.dr;
    assign WB_ENABLE = sets_cc(wb_q);

    sat_counter16 u_stall_cnt (
        .clk_i (CLK),
        .rst_i (RESET),
        .en_i  (STALL),
        .cnt_o (STALL_CNT)
    );

    sat_counter16 u_br_cnt (
        .clk_i (CLK),
        .rst_i (RESET),
        .en_i  (REDIRECT),
        .cnt_o (BR_CNT)
    );

endmodule
